pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It watches the ID, EX and MEM stages and drives the hold and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions:
- load-use hazards;
- taken branches and jumps resolved in MEM;
- multi-cycle data-memory accesses, using a valid/ready handshake and a timeout.

It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, MEM-stage redirects,
// multi-cycle data-memory waits with timeout, plus saturating stall/flush counters.
//
//   state | meaning
//   RUN   | normal flow, memory accesses that are ready at once cost nothing
//   MWAIT | data-memory access outstanding, pipeline held, wait_cnt counting
//   FAULT | memory timed out, pipeline frozen until rst
module pipe_hazard_ctrl #(
  parameter int PC_WIDTH       = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int RS_WIDTH       = 5,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RS_WIDTH-1:0]       rs1_id,
  input  logic [RS_WIDTH-1:0]       rs2_id,
  input  logic [RS_WIDTH-1:0]       rd_ex,
  input  logic                      memread_ex,
  input  logic                      branch_mem,
  input  logic                      alu_branch_mem,
  input  logic                      branchjalx_mem,
  input  logic                      alu2pc_mem,
  input  logic [PC_WIDTH-1:0]       sum_mem,
  input  logic [REG_DATA_WIDTH-1:0] alu_result_mem,
  input  logic                      memread_mem,
  input  logic                      memwrite_mem,
  input  logic                      dmem_ready,
  output logic                      dmem_valid,
  output logic                      pc_stall,
  output logic                      ifid_stall,
  output logic                      idex_stall,
  output logic                      exmem_stall,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exflush,
  output logic                      memwb_flush,
  output logic                      pc_redirect,
  output logic [PC_WIDTH-1:0]       pc_target,
  output logic                      mem_fault,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           mem_acc, taken, load_use, mem_wait;
  logic [PC_WIDTH-1:0] jalr_target;

  assign mem_acc  = memread_mem | memwrite_mem;
  assign taken    = (branch_mem & alu_branch_mem) | branchjalx_mem;
  assign load_use = memread_ex & (rd_ex != '0) & ((rd_ex == rs1_id) | (rd_ex == rs2_id));
  assign mem_wait = mem_acc & ~dmem_ready;

  assign jalr_target = alu_result_mem[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
  assign pc_target   = rst ? '0 : (alu2pc_mem ? jalr_target : sum_mem);

  always_comb begin
    dmem_valid   = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exflush      = 1'b0;
    memwb_flush  = 1'b0;
    pc_redirect  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    if (!rst) begin
      if (state == FAULT) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end else begin
        dmem_valid = mem_acc;
        if (mem_wait) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
        end else if (taken) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exflush     = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end

    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MWAIT: begin
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_fault <= mem_fault | (state_nxt == FAULT);
      // Counters stick at all-ones rather than wrapping.
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (pc_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: rule-level model compared every cycle, plus directed
// vectors with hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
  localparam int PCW = 32;
  localparam int RDW = 32;
  localparam int RSW = 5;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RSW-1:0] rs1_id, rs2_id, rd_ex;
  logic memread_ex, branch_mem, alu_branch_mem, branchjalx_mem, alu2pc_mem;
  logic [PCW-1:0] sum_mem;
  logic [RDW-1:0] alu_result_mem;
  logic memread_mem, memwrite_mem, dmem_ready;
  logic dmem_valid, pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, exflush, memwb_flush, pc_redirect, mem_fault;
  logic [PCW-1:0] pc_target;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(
    .PC_WIDTH(PCW), .REG_DATA_WIDTH(RDW), .RS_WIDTH(RSW),
    .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memread_ex(memread_ex), .branch_mem(branch_mem), .alu_branch_mem(alu_branch_mem),
    .branchjalx_mem(branchjalx_mem), .alu2pc_mem(alu2pc_mem), .sum_mem(sum_mem),
    .alu_result_mem(alu_result_mem), .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
    .dmem_ready(dmem_ready), .dmem_valid(dmem_valid), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exflush(exflush),
    .memwb_flush(memwb_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: rules applied directly, with the wait tracked as a plain count of misses.
  bit m_fault;
  int m_waited, m_stalls, m_flushes;
  logic acc, tk, lu;
  logic e_valid, e_pcs, e_ifs, e_ids, e_exs, e_iff, e_idf, e_exf, e_mwf, e_red;
  logic [PCW-1:0] e_tgt;

  assign acc = memread_mem | memwrite_mem;
  assign tk  = (branch_mem & alu_branch_mem) | branchjalx_mem;
  assign lu  = memread_ex && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);

  always_comb begin
    {e_valid, e_pcs, e_ifs, e_ids, e_exs, e_iff, e_idf, e_exf, e_mwf, e_red} = '0;
    e_tgt = '0;
    if (!rst) begin
      e_tgt = alu2pc_mem ? (alu_result_mem & 32'hFFFF_FFFE) : sum_mem;
      if (m_fault) begin
        {e_pcs, e_ifs, e_ids, e_exs} = 4'b1111;
      end else begin
        e_valid = acc;
        if (acc && !dmem_ready) {e_pcs, e_ifs, e_ids, e_exs, e_mwf} = 5'b11111;
        else if (tk) {e_red, e_iff, e_idf, e_exf} = 4'b1111;
        else if (lu) {e_pcs, e_ifs, e_idf} = 3'b111;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fault <= 1'b0; m_waited <= 0; m_stalls <= 0; m_flushes <= 0;
    end else begin
      if (!m_fault) begin
        if (acc && !dmem_ready) begin
          m_waited <= m_waited + 1;
          if (m_waited + 1 >= TMO) m_fault <= 1'b1;
        end else begin
          m_waited <= 0;
        end
      end
      if (e_pcs && m_stalls < CNT_MAX) m_stalls <= m_stalls + 1;
      if (e_red && m_flushes < CNT_MAX) m_flushes <= m_flushes + 1;
    end
  end

  always @(negedge clk) begin
    chk("dmem_valid", 64'(dmem_valid), 64'(e_valid));
    chk("pc_stall", 64'(pc_stall), 64'(e_pcs));
    chk("ifid_stall", 64'(ifid_stall), 64'(e_ifs));
    chk("idex_stall", 64'(idex_stall), 64'(e_ids));
    chk("exmem_stall", 64'(exmem_stall), 64'(e_exs));
    chk("ifid_flush", 64'(ifid_flush), 64'(e_iff));
    chk("idex_flush", 64'(idex_flush), 64'(e_idf));
    chk("exflush", 64'(exflush), 64'(e_exf));
    chk("memwb_flush", 64'(memwb_flush), 64'(e_mwf));
    chk("pc_redirect", 64'(pc_redirect), 64'(e_red));
    chk("pc_target", 64'(pc_target), 64'(e_tgt));
    chk("mem_fault", 64'(mem_fault), 64'(m_fault));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
  end

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_ex = 0; memread_ex = 0;
    branch_mem = 0; alu_branch_mem = 0; branchjalx_mem = 0; alu2pc_mem = 0;
    sum_mem = 0; alu_result_mem = 0; memread_mem = 0; memwrite_mem = 0; dmem_ready = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #3;
    chk("rst_pc_stall", 64'(pc_stall), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Load-use via rs1, then rd_ex=0, then via rs2.
    memread_ex = 1; rd_ex = 5; rs1_id = 5; #2;
    chk("lu_pc_stall", 64'(pc_stall), 64'd1);
    chk("lu_idex_flush", 64'(idex_flush), 64'd1);
    step(1); idle(); #2;
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    memread_ex = 1; rd_ex = 0; rs1_id = 0; #2;
    chk("lu_x0_no_stall", 64'(pc_stall), 64'd0);
    step(1); idle();
    memread_ex = 1; rd_ex = 7; rs2_id = 7; rs1_id = 3; #2;
    chk("lu_rs2_stall", 64'(ifid_stall), 64'd1);
    step(1); idle();

    // Branch, then jalr with odd target.
    branch_mem = 1; alu_branch_mem = 1; sum_mem = 32'h100; #2;
    chk("br_target", 64'(pc_target), 64'h100);
    chk("br_exflush", 64'(exflush), 64'd1);
    step(1); idle(); #2;
    chk("br_flush_cnt", 64'(flush_cnt), 64'd1);
    branchjalx_mem = 1; alu2pc_mem = 1; alu_result_mem = 32'h203; sum_mem = 32'h400; #2;
    chk("jalr_target", 64'(pc_target), 64'h202);
    step(1); idle();

    // Load-use together with a taken branch: redirect only.
    memread_ex = 1; rd_ex = 5; rs1_id = 5; branch_mem = 1; alu_branch_mem = 1; sum_mem = 32'h40; #2;
    chk("prio_no_stall", 64'(pc_stall), 64'd0);
    chk("prio_redirect", 64'(pc_redirect), 64'd1);
    step(1); idle(); #2;
    chk("prio_stall_cnt", 64'(stall_cnt), 64'd2);
    chk("prio_flush_cnt", 64'(flush_cnt), 64'd3);

    // Ready with no access is ignored.
    dmem_ready = 1; #2;
    chk("ready_no_acc_valid", 64'(dmem_valid), 64'd0);
    step(1); idle();

    // Memory wait: 3 misses then ready.
    reset_pulse();
    memread_mem = 1; dmem_ready = 0;
    step(1);
    memread_ex = 1; rd_ex = 5; rs1_id = 5; #2;
    chk("mw_lu_idex_flush", 64'(idex_flush), 64'd0);
    chk("mw_lu_exmem_stall", 64'(exmem_stall), 64'd1);
    step(1);
    memread_ex = 0;
    step(1);
    dmem_ready = 1; #2;
    chk("mw_ready_valid", 64'(dmem_valid), 64'd1);
    chk("mw_ready_no_stall", 64'(pc_stall), 64'd0);
    step(1); idle(); #2;
    chk("mw_stall_cnt", 64'(stall_cnt), 64'd3);

    // Reset in the middle of a wait.
    memwrite_mem = 1; dmem_ready = 0;
    step(2);
    rst = 1'b1; #1;
    chk("midrst_valid", 64'(dmem_valid), 64'd0);
    chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
    idle();
    step(1);
    rst = 1'b0;
    step(1);

    // Timeout with saturation of stall_cnt.
    memread_mem = 1; dmem_ready = 0;
    step(4); #2;
    chk("to_mem_fault", 64'(mem_fault), 64'd1);
    chk("to_valid", 64'(dmem_valid), 64'd0);
    chk("to_exmem_stall", 64'(exmem_stall), 64'd1);
    step(16); #2;
    chk("to_stall_sat", 64'(stall_cnt), 64'd15);
    rst = 1'b1; #1;
    chk("to_rst_fault", 64'(mem_fault), 64'd0);
    chk("to_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    idle();
    step(1);
    rst = 1'b0;
    step(1);

    // Saturation through 20 load-use cycles.
    memread_ex = 1; rd_ex = 9; rs2_id = 9;
    step(20); idle(); #2;
    chk("lu_stall_sat", 64'(stall_cnt), 64'd15);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
